// File: rtl/ds_pkg.sv
// Shared definitions for the 1-Wire frame layer: op codes, CRC polynomial
// and the frame FSM state type.
package ds_pkg;

  localparam logic [1:0] OP_RST = 2'd0;
  localparam logic [1:0] OP_WR  = 2'd1;
  localparam logic [1:0] OP_RD  = 2'd2;

  localparam logic [7:0] CRC_POLY = 8'h8C;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RST  = 3'd1,
    WR   = 3'd2,
    RD   = 3'd3,
    FIN  = 3'd4
  } state_t;

endpackage

// File: rtl/ds_crc8.sv
// Serial Dallas/Maxim CRC8 (reflected 0x8C), one bit per enabled cycle;
// a clear has priority over an update.
module ds_crc8
  import ds_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       bit_i,
  output logic [7:0] crc_o
);

  logic [7:0] crc_q, crc_d;
  logic       fb;

  always_comb begin
    crc_d = crc_q;
    fb    = crc_q[0] ^ bit_i;
    if (clr_i) begin
      crc_d = '0;
    end else if (en_i) begin
      crc_d = {1'b0, crc_q[7:1]} ^ (fb ? CRC_POLY : 8'h00);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/ds_intf_frame.sv
// 1-Wire frame layer: turns bus-reset / write / read commands into
// bit-layer requests, assembling bytes LSB first and checking read CRC.
module ds_intf_frame
  import ds_pkg::*;
#(
  parameter  int MAX_BYTES = 9,
  parameter  int CRC_EN    = 1,
  parameter  int GUARD     = 2,
  localparam int LEN_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_vld,
  input  logic [1:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [7:0]       wdata,
  output logic             wdata_req,
  output logic [7:0]       rdata,
  output logic             rdata_vld,
  output logic             done,
  output logic             crc_err,
  output logic             rdy,
  output logic             rst_en_bit,
  output logic             wr_en_bit,
  output logic             wdata_bit,
  output logic             rd_en_bit,
  input  logic             rdata_bit,
  input  logic             rdata_vld_bit,
  input  logic             rdy_bit
);

  localparam int               GW      = (GUARD < 1) ? 1 : $clog2(GUARD + 1);
  localparam logic [GW-1:0]    GUARD_V = GW'(GUARD);
  localparam logic [LEN_W-1:0] MAX_V   = LEN_W'(MAX_BYTES);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, byte_cnt_q, byte_cnt_d, next_byte, len_cl;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]    guard_q, guard_d;
  logic [7:0]       shreg_q, shreg_d, load, rdata_q, rdata_d;
  logic             chk_q, chk_d, pend_q, pend_d, need_byte_q, need_byte_d;
  logic             rst_en_q, rst_en_d, wr_en_q, wr_en_d, rd_en_q, rd_en_d;
  logic             wbit_q, wbit_d, rdata_vld_q, rdata_vld_d;
  logic             crc_err_q, crc_err_d, crc_err_now;
  logic             eligible, crc_clr, crc_en;
  logic [7:0]       crc;

  assign len_cl      = (cmd_len > MAX_V) ? MAX_V : cmd_len;
  assign next_byte   = byte_cnt_q + LEN_W'(1);
  assign eligible    = rdy_bit && (guard_q >= GUARD_V);
  // The CRC verdict is only final once the last bit has been folded in, i.e. in FIN.
  assign crc_err_now = (state_q == FIN) ? (chk_q && (crc != 8'h00)) : crc_err_q;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    byte_cnt_d  = byte_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    guard_d     = (guard_q >= GUARD_V) ? guard_q : guard_q + GW'(1);
    shreg_d     = shreg_q;
    rdata_d     = rdata_q;
    chk_d       = chk_q;
    pend_d      = pend_q;
    need_byte_d = need_byte_q;
    crc_err_d   = crc_err_q;
    rst_en_d    = 1'b0;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    wbit_d      = wbit_q;
    rdata_vld_d = 1'b0;
    wdata_req   = 1'b0;
    load        = shreg_q;
    crc_clr     = 1'b0;
    crc_en      = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_vld) begin
          len_d       = len_cl;
          byte_cnt_d  = '0;
          bit_cnt_d   = '0;
          guard_d     = GUARD_V;
          shreg_d     = '0;
          pend_d      = 1'b0;
          need_byte_d = 1'b1;
          chk_d       = (CRC_EN != 0) && (cmd_op == OP_RD);
          crc_err_d   = 1'b0;
          crc_clr     = 1'b1;
          case (cmd_op)
            OP_RST:  state_d = RST;
            OP_WR:   state_d = (len_cl == '0) ? FIN : WR;
            OP_RD:   state_d = (len_cl == '0) ? FIN : RD;
            default: state_d = FIN;
          endcase
        end
      end

      RST: begin
        if (eligible) begin
          if (!pend_q) begin
            rst_en_d = 1'b1;
            pend_d   = 1'b1;
            guard_d  = '0;
          end else begin
            state_d = FIN;
          end
        end
      end

      // A freshly requested byte is latched and may be sent in the same cycle.
      WR: begin
        wdata_req = need_byte_q;
        if (need_byte_q) begin
          load        = wdata;
          shreg_d     = wdata;
          need_byte_d = 1'b0;
        end
        if (eligible) begin
          if (byte_cnt_q == len_q) begin
            state_d = FIN;
          end else begin
            wr_en_d   = 1'b1;
            wbit_d    = load[0];
            shreg_d   = {1'b0, load[7:1]};
            guard_d   = '0;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              byte_cnt_d  = next_byte;
              need_byte_d = (next_byte < len_q);
            end
          end
        end
      end

      // One read slot outstanding at a time; pend_q marks an unanswered rd_en_bit.
      RD: begin
        if (pend_q && rdata_vld_bit) begin
          pend_d    = 1'b0;
          crc_en    = 1'b1;
          shreg_d   = {rdata_bit, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rdata_d     = {rdata_bit, shreg_q[7:1]};
            rdata_vld_d = 1'b1;
            byte_cnt_d  = next_byte;
            if (next_byte == len_q) begin
              state_d = FIN;
            end
          end
        end else if (!pend_q && eligible && (byte_cnt_q != len_q)) begin
          rd_en_d = 1'b1;
          pend_d  = 1'b1;
          guard_d = '0;
        end
      end

      FIN: begin
        state_d   = IDLE;
        crc_err_d = crc_err_now;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      byte_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      guard_q     <= '0;
      shreg_q     <= '0;
      rdata_q     <= '0;
      chk_q       <= 1'b0;
      pend_q      <= 1'b0;
      need_byte_q <= 1'b0;
      crc_err_q   <= 1'b0;
      rst_en_q    <= 1'b0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      wbit_q      <= 1'b0;
      rdata_vld_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      byte_cnt_q  <= byte_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      guard_q     <= guard_d;
      shreg_q     <= shreg_d;
      rdata_q     <= rdata_d;
      chk_q       <= chk_d;
      pend_q      <= pend_d;
      need_byte_q <= need_byte_d;
      crc_err_q   <= crc_err_d;
      rst_en_q    <= rst_en_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      wbit_q      <= wbit_d;
      rdata_vld_q <= rdata_vld_d;
    end
  end

  ds_crc8 u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (crc_clr),
    .en_i  (crc_en),
    .bit_i (rdata_bit),
    .crc_o (crc)
  );

  assign rdy        = (state_q == IDLE);
  assign done       = (state_q == FIN);
  assign crc_err    = crc_err_now;
  assign rdata      = rdata_q;
  assign rdata_vld  = rdata_vld_q;
  assign rst_en_bit = rst_en_q;
  assign wr_en_bit  = wr_en_q;
  assign rd_en_bit  = rd_en_q;
  assign wdata_bit  = wbit_q;

endmodule

// File: tb/tb_ds_intf_frame.sv
// Bench for ds_intf_frame: table of commands against a 1-Wire bit-layer model,
// with scoreboards for written bits and read bytes, plus corner sequences.
module tb_ds_intf_frame;

  logic       clk, rst_n, cmd_vld;
  logic [1:0] cmd_op;
  logic [3:0] cmd_len;
  logic [7:0] wdata, rdata;
  logic       wdata_req, rdata_vld, done, crc_err, rdy;
  logic       rst_en_bit, wr_en_bit, wdata_bit, rd_en_bit;
  logic       rdata_bit, rdata_vld_bit, rdy_bit;

  ds_intf_frame #(.MAX_BYTES(9), .CRC_EN(1), .GUARD(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_vld       (cmd_vld),
    .cmd_op        (cmd_op),
    .cmd_len       (cmd_len),
    .wdata         (wdata),
    .wdata_req     (wdata_req),
    .rdata         (rdata),
    .rdata_vld     (rdata_vld),
    .done          (done),
    .crc_err       (crc_err),
    .rdy           (rdy),
    .rst_en_bit    (rst_en_bit),
    .wr_en_bit     (wr_en_bit),
    .wdata_bit     (wdata_bit),
    .rd_en_bit     (rd_en_bit),
    .rdata_bit     (rdata_bit),
    .rdata_vld_bit (rdata_vld_bit),
    .rdy_bit       (rdy_bit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [3:0] len;
    int         dataSel;
    int         expRst;
    int         expWr;
    int         expRd;
    int         expReq;
    int         expVld;
    int         expCrc;
  } vec_t;

  vec_t       vecs[8];
  logic [7:0] goodPad[9] = '{8'h50, 8'h05, 8'h4B, 8'h46, 8'h7F, 8'hFF, 8'h0C, 8'h10, 8'h1C};

  int passCount = 0, checkCount = 0;
  int rstCnt, wrCnt, rdCnt, reqCnt, vldCnt, doneCnt, crcAtDone;
  logic       wbitExp[$];
  logic       readBits[$];
  logic [7:0] rbyteExp[$];
  logic [7:0] wrBytes[$];
  logic       monBit;
  logic [7:0] monByte;
  int         busy;
  logic       rdPend;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
  endtask

  task automatic clearCounts();
    rstCnt = 0; wrCnt = 0; rdCnt = 0; reqCnt = 0; vldCnt = 0; doneCnt = 0; crcAtDone = 0;
  endtask

  task automatic setupData(input logic [1:0] op, input int sel);
    logic [7:0] b[$];
    b = {};
    case (sel)
      1: begin b.push_back(8'hCC); b.push_back(8'h44); end
      2: for (int i = 0; i < 9; i++) b.push_back(goodPad[i]);
      3: for (int i = 0; i < 9; i++) b.push_back((i == 8) ? 8'h1D : goodPad[i]);
      4: b.push_back(8'hA5);
      5: b.push_back(8'h5A);
      default: ;
    endcase
    foreach (b[i]) begin
      if (op == 2'd1) begin
        wrBytes.push_back(b[i]);
        for (int j = 0; j < 8; j++) wbitExp.push_back(b[i][j]);
      end else if (op == 2'd2) begin
        rbyteExp.push_back(b[i]);
        for (int j = 0; j < 8; j++) readBits.push_back(b[i][j]);
      end
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [3:0] len);
    int n;
    n = 0;
    while (!rdy && n < 100) begin @(negedge clk); n++; end
    if (!rdy) checkOutput("rdy_before_cmd", 0, 1);
    cmd_vld = 1'b1; cmd_op = op; cmd_len = len;
    @(negedge clk);
    cmd_vld = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int n;
    n = 0;
    while (doneCnt == 0 && n < budget) begin @(negedge clk); n++; end
    if (doneCnt == 0) checkOutput("done_timeout", 0, 1);
  endtask

  // Monitor / scoreboard: counts pulses, supplies write bytes, pops expectations.
  initial begin
    wdata = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (rst_en_bit) rstCnt++;
        if (rd_en_bit) rdCnt++;
        if (wr_en_bit) begin
          wrCnt++;
          if (wbitExp.size() == 0) checkOutput("wbit_unexpected", 1, 0);
          else begin monBit = wbitExp.pop_front(); checkOutput("wdata_bit", wdata_bit, monBit); end
        end
        if (wdata_req) begin
          reqCnt++;
          if (wrBytes.size() == 0) checkOutput("wdata_req_unexpected", 1, 0);
          else wdata = wrBytes.pop_front();
        end
        if (rdata_vld) begin
          vldCnt++;
          if (rbyteExp.size() == 0) checkOutput("rdata_unexpected", 1, 0);
          else begin monByte = rbyteExp.pop_front(); checkOutput("rdata", rdata, monByte); end
        end
        if (done) begin doneCnt++; crcAtDone = crc_err; end
      end
    end
  end

  // Bit-layer model: busy 20 cycles per enable; a read answers mid-slot.
  initial begin
    rdy_bit = 1'b1; rdata_bit = 1'b0; rdata_vld_bit = 1'b0; busy = 0; rdPend = 1'b0;
    forever begin
      @(negedge clk);
      rdata_vld_bit = 1'b0;
      if (!rst_n) begin
        busy = 0; rdPend = 1'b0; rdy_bit = 1'b1;
      end else if (rst_en_bit || wr_en_bit || rd_en_bit) begin
        busy = 20; rdy_bit = 1'b0; rdPend = rd_en_bit;
      end else if (busy > 0) begin
        busy--;
        if (rdPend && busy == 10) begin
          rdata_vld_bit = 1'b1;
          rdata_bit = (readBits.size() > 0) ? readBits.pop_front() : 1'b0;
          rdPend = 1'b0;
        end
        if (busy == 0) rdy_bit = 1'b1;
      end
    end
  end

  initial begin
    vecs[0] = '{2'd0, 4'd0,  0, 1, 0,  0,  0, 0, 0};
    vecs[1] = '{2'd1, 4'd2,  1, 0, 16, 0,  2, 0, 0};
    vecs[2] = '{2'd2, 4'd9,  2, 0, 0,  72, 0, 9, 0};
    vecs[3] = '{2'd2, 4'd9,  3, 0, 0,  72, 0, 9, 1};
    vecs[4] = '{2'd1, 4'd0,  0, 0, 0,  0,  0, 0, 0};
    vecs[5] = '{2'd3, 4'd5,  0, 0, 0,  0,  0, 0, 0};
    vecs[6] = '{2'd2, 4'd15, 2, 0, 0,  72, 0, 9, 0};
    vecs[7] = '{2'd1, 4'd1,  4, 0, 8,  0,  1, 0, 0};

    rst_n = 1'b0; cmd_vld = 1'b0; cmd_op = 2'd0; cmd_len = 4'd0;
    clearCounts();
    repeat (3) @(negedge clk);
    checkOutput("reset_rdy", rdy, 1);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_bit_outs", {rst_en_bit, wr_en_bit, rd_en_bit, wdata_bit}, 0);
    checkOutput("reset_data_outs", {wdata_req, rdata_vld, crc_err, rdata}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      clearCounts();
      setupData(vecs[v].op, vecs[v].dataSel);
      applyStimulus(vecs[v].op, vecs[v].len);
      waitDone(6000);
      @(negedge clk);
      $display("[TB] vector %0d op=%0d len=%0d complete", v, vecs[v].op, vecs[v].len);
      checkOutput("rst_en_count", rstCnt, vecs[v].expRst);
      checkOutput("wr_en_count", wrCnt, vecs[v].expWr);
      checkOutput("rd_en_count", rdCnt, vecs[v].expRd);
      checkOutput("wdata_req_count", reqCnt, vecs[v].expReq);
      checkOutput("rdata_vld_count", vldCnt, vecs[v].expVld);
      checkOutput("done_count", doneCnt, 1);
      checkOutput("crc_err_at_done", crcAtDone, vecs[v].expCrc);
      checkOutput("crc_err_held", crc_err, vecs[v].expCrc);
      checkOutput("rdy_after_done", rdy, 1);
      checkOutput("wbit_left", wbitExp.size(), 0);
      checkOutput("rbyte_left", rbyteExp.size(), 0);
    end

    // Zero-length read: done exactly at T+1, then idle.
    clearCounts();
    applyStimulus(2'd2, 4'd0);
    checkOutput("zero_len_done_t1", done, 1);
    checkOutput("zero_len_rdy_t1", rdy, 0);
    checkOutput("zero_len_crc_t1", crc_err, 0);
    @(negedge clk);
    checkOutput("zero_len_done_t2", done, 0);
    checkOutput("zero_len_rdy_t2", rdy, 1);

    // Commands while busy are dropped, not queued.
    clearCounts();
    setupData(2'd1, 5);
    applyStimulus(2'd1, 4'd1);
    repeat (3) @(negedge clk);
    cmd_vld = 1'b1; cmd_op = 2'd0; cmd_len = 4'd0;
    repeat (4) @(negedge clk);
    cmd_vld = 1'b0;
    waitDone(6000);
    repeat (40) @(negedge clk);
    checkOutput("busy_done_count", doneCnt, 1);
    checkOutput("busy_rst_en_count", rstCnt, 0);
    checkOutput("busy_wr_en_count", wrCnt, 8);

    // Reset in the middle of a read aborts it without done or retry.
    clearCounts();
    setupData(2'd2, 2);
    applyStimulus(2'd2, 4'd9);
    repeat (80) @(negedge clk);
    checkOutput("abort_started", (rdCnt > 0) ? 1 : 0, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_rdy", rdy, 1);
    checkOutput("abort_outs", {done, crc_err, rdata_vld, wdata_req, rst_en_bit, wr_en_bit, rd_en_bit, wdata_bit, rdata}, 0);
    readBits.delete();
    rbyteExp.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clearCounts();
    repeat (300) @(negedge clk);
    checkOutput("abort_no_done", doneCnt, 0);
    checkOutput("abort_no_retry", rdCnt, 0);
    checkOutput("abort_idle_rdy", rdy, 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
